// File: rtl/ibuf.sv
//============================================================================
// Module   : ibuf
// Purpose  : Per-virtual-channel input flit buffer. Incoming flits are kept
//            in a circular FIFO. The oldest flit is presented on bdata, and
//            one flit is popped per cycle while the downstream VC asserts
//            send. Free space is advertised upstream on ordy.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk     in   1            clock, rising edge
//   rst_    in   1            asynchronous reset, active low
//   idata   in   [`DATAW:0]   incoming flit
//   ivalid  in   1            idata valid this cycle
//   ordy    out  1            buffer can accept a flit (to upstream irdy)
//   bdata   out  [`DATAW:0]   head-of-queue flit (TYPE_NONE when empty)
//   send    in   1            pop request from the VC state machine
//   count   out  [PTRW+1:0]   current occupancy, 0..DEPTH
//   err     out  1            sticky protocol/overflow error
//
// Optional feature
//   IBUF_ERRCHK_EN : when defined, packet framing is tracked and err is
//                    raised on overflow, framing violations and underrun
//                    pops. When undefined, err is tied low.
//
// Flit format (defaults, overridable before this file is compiled)
//   [`TYPE_MSB:`TYPE_LSB] flit type, [31:0] payload
//============================================================================

`default_nettype none

`ifndef DATAW
`define DATAW 34
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 34
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 32
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 3'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'd1
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 3'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'd3
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 3'd4
`endif

module ibuf #(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int VCHID    = 0,
  parameter int DEPTH    = 4,
  parameter int PTRW     = 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [`DATAW:0]  idata,
  input  logic             ivalid,
  output logic             ordy,
  output logic [`DATAW:0]  bdata,
  input  logic             send,
  output logic [PTRW+1:0]  count,
  output logic             err
);

  // Occupancy value that means "every entry holds a flit".
  localparam logic [PTRW+1:0] c_FULL = (PTRW+2)'(DEPTH);

  // The identification parameters only label the instance for debug; this
  // sink keeps them referenced without producing any hardware.
  logic [31:0] w_unused_diag;
  assign w_unused_diag = 32'(ROUTERID) ^ 32'(PCHID) ^ 32'(VCHID);

  //--------------------------------------------------------------------------
  // Storage and state
  //--------------------------------------------------------------------------
  logic [`DATAW:0] r_mem [DEPTH];
  logic [PTRW:0]   r_wp;
  logic [PTRW:0]   r_rp;
  logic [PTRW+1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_rd;
  logic w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);

  // A pop is only honoured when there is something to pop. A push is
  // accepted when there is room, or when a pop frees a slot on the same
  // edge. This lets a full buffer stream at one flit per cycle.
  assign w_rd = send && !w_empty;
  assign w_wr = ivalid && (!w_full || w_rd);

  // ordy depends only on registered occupancy. This keeps the upstream
  // handshake free of combinational paths through ivalid or send.
  assign ordy  = !w_full;
  assign count = r_count;

  //--------------------------------------------------------------------------
  // Data array: no reset. Contents are only observable through rp while
  // the occupancy is non-zero.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= idata;
    end
  end

  //--------------------------------------------------------------------------
  // Pointers and occupancy. The pointers are exactly log2(DEPTH) bits wide,
  // so they wrap from DEPTH-1 to 0 without any compare logic.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Head-of-queue output. An empty buffer shows a NONE flit so the VC
  // cannot act on a stale HEAD left in the array.
  //--------------------------------------------------------------------------
  always_comb begin
    bdata = '0;
    bdata[`TYPE_MSB:`TYPE_LSB] = `TYPE_NONE;
    if (!w_empty) begin
      bdata = r_mem[r_rp];
    end
  end

  //--------------------------------------------------------------------------
  // Optional protocol checking
  //--------------------------------------------------------------------------
`ifdef IBUF_ERRCHK_EN
  logic       r_in_pkt;
  logic       r_err;
  logic       w_in_pkt_nxt;
  logic       w_frame_err;
  logic       w_overflow;
  logic       w_underrun;
  logic [2:0] w_itype;

  assign w_itype    = idata[`TYPE_MSB:`TYPE_LSB];
  assign w_overflow = ivalid && w_full && !w_rd;
  assign w_underrun = send && w_empty;

  // Framing is judged only on flits that are actually stored. A dropped
  // flit is already reported as an overflow, and it must not disturb
  // in_pkt.
  always_comb begin
    w_in_pkt_nxt = r_in_pkt;
    w_frame_err  = 1'b0;
    if (w_wr) begin
      case (w_itype)
        `TYPE_HEAD: begin
          w_frame_err  = r_in_pkt;
          w_in_pkt_nxt = 1'b1;
        end
        `TYPE_HEADTAIL: begin
          w_frame_err  = r_in_pkt;
          w_in_pkt_nxt = 1'b0;
        end
        `TYPE_BODY: begin
          w_frame_err  = !r_in_pkt;
        end
        `TYPE_TAIL: begin
          w_frame_err  = !r_in_pkt;
          w_in_pkt_nxt = 1'b0;
        end
        default: begin
          w_frame_err  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_in_pkt <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_in_pkt <= w_in_pkt_nxt;
      if (w_overflow || w_frame_err || w_underrun) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibuf.sv
//============================================================================
// Module   : tb_ibuf
// Purpose  : Directed self-checking bench for ibuf (DEPTH=4).
// Revision : 1.0 - initial release
//============================================================================

`default_nettype none

`ifndef DATAW
`define DATAW 34
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 34
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 32
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 3'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'd1
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 3'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'd3
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 3'd4
`endif

module tb_ibuf;

`ifdef IBUF_ERRCHK_EN
  localparam logic c_ERRCHK = 1'b1;
`else
  localparam logic c_ERRCHK = 1'b0;
`endif

  logic            clk;
  logic            rst_;
  logic [`DATAW:0] idata;
  logic            ivalid;
  logic            ordy;
  logic [`DATAW:0] bdata;
  logic            send;
  logic [2:0]      count;
  logic            err;

  int n_tests;
  int n_fail;

  ibuf #(
    .ROUTERID (0),
    .PCHID    (0),
    .VCHID    (0),
    .DEPTH    (4),
    .PTRW     (1)
  ) dut (
    .clk    (clk),
    .rst_   (rst_),
    .idata  (idata),
    .ivalid (ivalid),
    .ordy   (ordy),
    .bdata  (bdata),
    .send   (send),
    .count  (count),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [`DATAW:0] mk(input logic [2:0] t, input logic [31:0] p);
    logic [`DATAW:0] f;
    f = '0;
    f[`TYPE_MSB:`TYPE_LSB] = t;
    f[31:0] = p;
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    #2;
    rst_ = 1'b1;
  endtask

  logic [`DATAW:0] exp_q [4];
  logic [2:0]      t_prev;
  logic [2:0]      t_cur;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_    = 1'b0;
    ivalid  = 1'b0;
    send    = 1'b0;
    idata   = '0;

    // Reset state
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_ordy",  64'(ordy),  64'd1);
    check("rst_bdata", 64'(bdata), 64'(mk(`TYPE_NONE, 32'h0)));
    check("rst_err",   64'(err),   64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    tick();

    // HEAD, BODY, TAIL with no pops
    ivalid = 1'b1;
    idata  = mk(`TYPE_HEAD, 32'h11);
    tick();
    check("hbt_first_vis", 64'(bdata), 64'(mk(`TYPE_HEAD, 32'h11)));
    check("hbt_cnt1",      64'(count), 64'd1);
    idata = mk(`TYPE_BODY, 32'h22);
    tick();
    idata = mk(`TYPE_TAIL, 32'h33);
    tick();
    ivalid = 1'b0;
    check("hbt_cnt3",  64'(count), 64'd3);
    check("hbt_ordy",  64'(ordy),  64'd1);
    check("hbt_bdata", 64'(bdata), 64'(mk(`TYPE_HEAD, 32'h11)));

    // Fill to DEPTH, then overflow
    ivalid = 1'b1;
    idata  = mk(`TYPE_HEADTAIL, 32'h44);
    tick();
    check("full_cnt",  64'(count), 64'd4);
    check("full_ordy", 64'(ordy),  64'd0);
    idata = mk(`TYPE_HEADTAIL, 32'h55);
    tick();
    ivalid = 1'b0;
    check("ovf_cnt",   64'(count), 64'd4);
    check("ovf_err",   64'(err),   64'(c_ERRCHK));
    check("ovf_bdata", 64'(bdata), 64'(mk(`TYPE_HEAD, 32'h11)));

    // Simultaneous push and pop while full
    ivalid = 1'b1;
    send   = 1'b1;
    idata  = mk(`TYPE_HEADTAIL, 32'h66);
    tick();
    ivalid = 1'b0;
    send   = 1'b0;
    check("fullrw_cnt",  64'(count), 64'd4);
    check("fullrw_ordy", 64'(ordy),  64'd0);
    exp_q[0] = mk(`TYPE_BODY,     32'h22);
    exp_q[1] = mk(`TYPE_TAIL,     32'h33);
    exp_q[2] = mk(`TYPE_HEADTAIL, 32'h44);
    exp_q[3] = mk(`TYPE_HEADTAIL, 32'h66);
    send = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), 64'(bdata), 64'(exp_q[i]));
      tick();
    end
    send = 1'b0;
    check("drain_cnt",   64'(count), 64'd0);
    check("drain_bdata", 64'(bdata), 64'(mk(`TYPE_NONE, 32'h0)));

    // Push and pop together on an empty buffer
    do_reset();
    check("rst2_cnt", 64'(count), 64'd0);
    check("rst2_err", 64'(err),   64'd0);
    ivalid = 1'b1;
    send   = 1'b1;
    idata  = mk(`TYPE_HEADTAIL, 32'h5A);
    tick();
    ivalid = 1'b0;
    send   = 1'b0;
    check("emptyrw_cnt",   64'(count), 64'd1);
    check("emptyrw_bdata", 64'(bdata), 64'(mk(`TYPE_HEADTAIL, 32'h5A)));
    check("emptyrw_err",   64'(err),   64'(c_ERRCHK));
    tick();
    check("emptyrw_hold", 64'(bdata), 64'(mk(`TYPE_HEADTAIL, 32'h5A)));

    // Ten-flit stream with send held: pointers wrap twice
    do_reset();
    ivalid = 1'b1;
    idata  = mk(`TYPE_HEAD, 32'd100);
    tick();
    send   = 1'b1;
    t_prev = `TYPE_HEAD;
    for (int k = 1; k < 10; k++) begin
      t_cur = (k == 9) ? `TYPE_TAIL : `TYPE_BODY;
      idata = mk(t_cur, 32'(100 + k));
      check($sformatf("stream_%0d", k - 1), 64'(bdata), 64'(mk(t_prev, 32'(100 + k - 1))));
      check($sformatf("stream_cnt_%0d", k), 64'(count), 64'd1);
      tick();
      t_prev = t_cur;
    end
    ivalid = 1'b0;
    check("stream_9", 64'(bdata), 64'(mk(`TYPE_TAIL, 32'd109)));
    tick();
    send = 1'b0;
    check("stream_end_cnt", 64'(count), 64'd0);
    check("stream_err",     64'(err),   64'd0);
    check("stream_ordy",    64'(ordy),  64'd1);

    // Asynchronous reset mid-clock with three flits held
    ivalid = 1'b1;
    idata  = mk(`TYPE_HEAD, 32'h71);
    tick();
    idata = mk(`TYPE_BODY, 32'h72);
    tick();
    idata = mk(`TYPE_TAIL, 32'h73);
    tick();
    ivalid = 1'b0;
    check("pre_arst_cnt", 64'(count), 64'd3);
    @(negedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_cnt",   64'(count), 64'd0);
    check("arst_ordy",  64'(ordy),  64'd1);
    check("arst_bdata", 64'(bdata), 64'(mk(`TYPE_NONE, 32'h0)));
    @(negedge clk);
    rst_ = 1'b1;
    tick();
    ivalid = 1'b1;
    idata  = mk(`TYPE_HEAD, 32'h99);
    tick();
    ivalid = 1'b0;
    check("post_arst_bdata", 64'(bdata), 64'(mk(`TYPE_HEAD, 32'h99)));
    check("post_arst_cnt",   64'(count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
